// File: rtl/framebuffer_fill_if.sv
// Command, swap and framebuffer-write signals of the framebuffer_fill drawing engine.
// The slave modport is the engine; the master modport is whoever drives commands.
interface framebuffer_fill_if #(
    parameter int ADDR_W  = 19,
    parameter int COORD_W = 10
);
    // Command handshake: a command transfers on a clock edge where cmd_valid and cmd_ready are both high.
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;
    logic [COORD_W-1:0] cmd_w;
    logic [COORD_W-1:0] cmd_h;
    logic [3:0]         cmd_color;
    logic               swap_req;
    logic               frame_start;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [3:0]         fb_data;
    logic               front_buf;
    logic               busy;
    logic               done;
    logic               cmd_error;
    logic [1:0]         dbg_state;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, swap_req, frame_start,
        input  cmd_ready, fb_we, fb_addr, fb_data, front_buf, busy, done, cmd_error, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, swap_req, frame_start,
        output cmd_ready, fb_we, fb_addr, fb_data, front_buf, busy, done, cmd_error, dbg_state
    );
endinterface

// File: rtl/framebuffer_fill.sv
// Solid-rectangle fill engine for a double-buffered 4-bit framebuffer; swaps deferred to frame start.
// Define FRAMEBUFFER_FILL_CLIP_EN to clip rectangles to the screen instead of rejecting them.
module framebuffer_fill #(
    parameter int H_RES   = 400,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int COORD_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    framebuffer_fill_if.slave bus
);
    localparam int CW1 = COORD_W + 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FILL      = 2'd1;
    localparam logic [1:0] ST_SWAP_WAIT = 2'd2;

    localparam logic [CW1-1:0]     H_LIM    = CW1'(H_RES);
    localparam logic [CW1-1:0]     V_LIM    = CW1'(V_RES);
    localparam logic [ADDR_W-1:0]  BUF_SIZE = ADDR_W'(H_RES * V_RES);
    localparam logic [ADDR_W-1:0]  H_STEP   = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0]  A_ONE    = ADDR_W'(1);
    localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);

    logic [1:0]         state_q, state_d;
    logic               front_q, front_d;
    logic               pend_q, pend_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [3:0]         color_q, color_d;
    logic [COORD_W-1:0] w_q, w_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic [CW1-1:0]     x_ext, y_ext, x_sum, y_sum;
    logic [COORD_W-1:0] eff_w, eff_h;
    logic [COORD_W-1:0] w_last, h_last;
    logic [ADDR_W-1:0]  start_row;
    logic               reject;
    logic               ready;
    logic               accept;

    assign x_ext  = {1'b0, bus.cmd_x};
    assign y_ext  = {1'b0, bus.cmd_y};
    assign x_sum  = x_ext + {1'b0, bus.cmd_w};
    assign y_sum  = y_ext + {1'b0, bus.cmd_h};
    assign w_last = w_q - C_ONE;
    assign h_last = h_q - C_ONE;

    // Reset gates ready so the handshake is dead while the engine is held in reset.
    assign ready  = (state_q == ST_IDLE) && !bus.swap_req && !pend_q && !reset;
    assign accept = bus.cmd_valid && ready;

    // Constant-coefficient product, evaluated once per command; the fill itself only adds.
    assign start_row = (front_q ? '0 : BUF_SIZE) + ADDR_W'(bus.cmd_y) * H_STEP;

    always_comb begin
`ifdef FRAMEBUFFER_FILL_CLIP_EN
        reject = 1'b0;
        if ((x_ext >= H_LIM) || (y_ext >= V_LIM)) begin
            eff_w = '0;
            eff_h = '0;
        end else begin
            eff_w = (x_sum > H_LIM) ? COORD_W'(H_LIM - x_ext) : bus.cmd_w;
            eff_h = (y_sum > V_LIM) ? COORD_W'(V_LIM - y_ext) : bus.cmd_h;
        end
`else
        reject = (x_sum > H_LIM) || (y_sum > V_LIM);
        eff_w  = bus.cmd_w;
        eff_h  = bus.cmd_h;
`endif
    end

    always_comb begin
        state_d    = state_q;
        front_d    = front_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        color_d    = color_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        x_d        = x_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;

        if ((state_q != ST_IDLE) && bus.swap_req) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.swap_req || pend_q) begin
                    state_d = ST_SWAP_WAIT;
                    pend_d  = 1'b0;
                end else if (accept) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else if ((eff_w == '0) || (eff_h == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_FILL;
                        color_d    = bus.cmd_color;
                        w_d        = eff_w;
                        h_d        = eff_h;
                        col_d      = '0;
                        row_d      = '0;
                        x_d        = bus.cmd_x;
                        row_base_d = start_row;
                        addr_d     = start_row + ADDR_W'(bus.cmd_x);
                    end
                end
            end

            ST_FILL: begin
                if (col_q == w_last) begin
                    col_d = '0;
                    if (row_q == h_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d      = row_q + C_ONE;
                        row_base_d = row_base_q + H_STEP;
                        addr_d     = row_base_q + H_STEP + ADDR_W'(x_q);
                    end
                end else begin
                    col_d  = col_q + C_ONE;
                    addr_d = addr_q + A_ONE;
                end
            end

            // A frame_start seen while still in IDLE is ignored; only one inside SWAP_WAIT counts.
            ST_SWAP_WAIT: begin
                if (bus.frame_start) begin
                    front_d = !front_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            front_q    <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            color_q    <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            front_q    <= front_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            err_q      <= err_d;
            color_q    <= color_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            x_q        <= x_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.fb_we     = (state_q == ST_FILL);
    assign bus.fb_addr   = addr_q;
    assign bus.fb_data   = color_q;
    assign bus.front_buf = front_q;
    assign bus.busy      = (state_q == ST_FILL) || (state_q == ST_SWAP_WAIT);
    assign bus.done      = done_q;
    assign bus.cmd_error = err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_framebuffer_fill.sv
// Scoreboard bench for framebuffer_fill: drivers push cycle-stamped expected events, a monitor pops them.
// Clip-dependent expectations follow FRAMEBUFFER_FILL_CLIP_EN.
module tb_framebuffer_fill;
    localparam int ADDR_W  = 19;
    localparam int COORD_W = 10;
    localparam int EW      = 32 + 2 + ADDR_W + 4;

    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    localparam int M_FILL = 0;
    localparam int M_DONE = 1;
    localparam int M_ERR  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    framebuffer_fill_if #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) bus_if ();

    framebuffer_fill #(
        .H_RES(400), .V_RES(480), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int   n_vec     = 0;
    int   n_fail    = 0;
    logic exp_front = 1'b0;

    task automatic push_evt(input int c, input logic [1:0] kind, input int addr, input int data);
        exp_q.push_back({32'(c), kind, ADDR_W'(addr), 4'(data)});
    endtask

    task automatic check_evt(input logic [1:0] kind, input logic [ADDR_W-1:0] addr, input logic [3:0] data);
        logic [EW-1:0] act;
        logic [EW-1:0] req;
        act = {32'(cyc), kind, addr, data};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL evt: got cyc=%0d kind=%0d addr=%0d data=%0d, required no event",
                     cyc, kind, addr, data);
        end else begin
            req = exp_q.pop_front();
            if (act !== req) begin
                n_fail++;
                $display("FAIL evt: got cyc=%0d kind=%0d addr=%0d data=%0d, required cyc=%0d kind=%0d addr=%0d data=%0d",
                         act[EW-1 -: 32], act[ADDR_W+5 -: 2], act[ADDR_W+3 -: ADDR_W], act[3:0],
                         req[EW-1 -: 32], req[ADDR_W+5 -: 2], req[ADDR_W+3 -: ADDR_W], req[3:0]);
            end
        end
    endtask

    // Monitor: every write, done or error the DUT presents must match the head of the queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus_if.fb_we)     check_evt(K_WR, bus_if.fb_addr, bus_if.fb_data);
            if (bus_if.done)      check_evt(K_DONE, '0, '0);
            if (bus_if.cmd_error) check_evt(K_ERR, '0, '0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic issue(input int x, input int y, input int w, input int h, input int color,
                         input int mode, input int base, input int ew, input int eh);
        int t;
        int acc;
        @(negedge clock);
        bus_if.cmd_x     = COORD_W'(x);
        bus_if.cmd_y     = COORD_W'(y);
        bus_if.cmd_w     = COORD_W'(w);
        bus_if.cmd_h     = COORD_W'(h);
        bus_if.cmd_color = 4'(color);
        bus_if.cmd_valid = 1'b1;
        #1;
        t = 0;
        while (!bus_if.cmd_ready && t < 500) begin
            @(negedge clock);
            #1;
            t++;
        end
        n_vec++;
        if (!bus_if.cmd_ready) begin
            n_fail++;
            $display("FAIL accept: cmd_ready=0 after %0d cycles, required 1", t);
        end else begin
            acc = cyc;
            if (mode == M_FILL) begin
                for (int r = 0; r < eh; r++)
                    for (int c = 0; c < ew; c++)
                        push_evt(acc + 1 + r * ew + c, K_WR, base + (y + r) * 400 + x + c, color);
                push_evt(acc + 1 + ew * eh, K_DONE, 0, 0);
            end else if (mode == M_DONE) begin
                push_evt(acc + 1, K_DONE, 0, 0);
            end else begin
                push_evt(acc + 1, K_ERR, 0, 0);
            end
        end
        @(negedge clock);
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            @(negedge clock);
            #1;
            t++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_swap(input int delay);
        @(negedge clock);
        bus_if.swap_req = 1'b1;
        #1;
        chk("ready_low_on_swap_req", 32'(bus_if.cmd_ready), 32'd0);
        @(negedge clock);
        bus_if.swap_req = 1'b0;
        #1;
        chk("swap_wait_busy", 32'(bus_if.busy), 32'd1);
        chk("swap_wait_ready", 32'(bus_if.cmd_ready), 32'd0);
        chk("swap_wait_front", 32'(bus_if.front_buf), 32'(exp_front));
        repeat (delay - 1) @(negedge clock);
        bus_if.frame_start = 1'b1;
        push_evt(cyc + 1, K_DONE, 0, 0);
        @(negedge clock);
        bus_if.frame_start = 1'b0;
        #1;
        exp_front = ~exp_front;
        chk("swap_front", 32'(bus_if.front_buf), 32'(exp_front));
        chk("swap_idle", 32'(bus_if.busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_x       = '0;
        bus_if.cmd_y       = '0;
        bus_if.cmd_w       = '0;
        bus_if.cmd_h       = '0;
        bus_if.cmd_color   = '0;
        bus_if.swap_req    = 1'b0;
        bus_if.frame_start = 1'b0;

        repeat (3) @(negedge clock);
        #1;
        chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        chk("rst_front_buf", 32'(bus_if.front_buf), 32'd0);
        chk("rst_fb_we", 32'(bus_if.fb_we), 32'd0);
        chk("rst_fb_addr", 32'(bus_if.fb_addr), 32'd0);
        chk("rst_fb_data", 32'(bus_if.fb_data), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_cmd_error", 32'(bus_if.cmd_error), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("post_rst_ready", 32'(bus_if.cmd_ready), 32'd1);

        // Basic 3x2 fill into back buffer 1: 192402..192404, 192802..192804.
        issue(2, 1, 3, 2, 5, M_FILL, 192000, 3, 2);
        wait_drain(100);

        // IDLE swaps with frame_start 10 and 4 cycles after the request.
        do_swap(10);
        do_swap(4);

        // 100-pixel fill into buffer 1 with two swap requests folded into one later swap.
        issue(0, 10, 100, 1, 3, M_FILL, 192000, 100, 1);
        repeat (20) @(negedge clock);
        bus_if.swap_req = 1'b1;
        #1;
        chk("ready_low_in_fill", 32'(bus_if.cmd_ready), 32'd0);
        @(negedge clock);
        bus_if.swap_req = 1'b0;
        repeat (30) @(negedge clock);
        bus_if.swap_req = 1'b1;
        @(negedge clock);
        bus_if.swap_req = 1'b0;
        #1;
        chk("front_hold_mid_fill", 32'(bus_if.front_buf), 32'd0);
        wait_drain(300);
        @(negedge clock);
        #1;
        chk("pending_swap_busy", 32'(bus_if.busy), 32'd1);
        chk("pending_swap_state", 32'(bus_if.dbg_state), 32'd2);
        bus_if.frame_start = 1'b1;
        push_evt(cyc + 1, K_DONE, 0, 0);
        @(negedge clock);
        bus_if.frame_start = 1'b0;
        #1;
        exp_front = 1'b1;
        chk("pending_swap_front", 32'(bus_if.front_buf), 32'd1);
        repeat (5) @(negedge clock);
        #1;
        chk("single_swap_only", 32'(bus_if.busy), 32'd0);
        chk("single_swap_front", 32'(bus_if.front_buf), 32'd1);

        // Next fill now targets buffer 0: addresses 5, 6.
        issue(5, 0, 2, 1, 9, M_FILL, 0, 2, 1);
        wait_drain(50);

        do_swap(3);

`ifdef FRAMEBUFFER_FILL_CLIP_EN
        issue(398, 0, 5, 1, 7, M_FILL, 192000, 2, 1);
        wait_drain(50);
        issue(0, 479, 1, 2, 8, M_FILL, 192000, 1, 1);
        wait_drain(50);
        issue(400, 0, 1, 1, 2, M_DONE, 0, 0, 0);
        wait_drain(50);
`else
        issue(398, 0, 5, 1, 7, M_ERR, 0, 0, 0);
        wait_drain(50);
        #1;
        chk("reject_stays_idle", 32'(bus_if.dbg_state), 32'd0);
        chk("reject_ready", 32'(bus_if.cmd_ready), 32'd1);
        issue(0, 479, 1, 2, 8, M_ERR, 0, 0, 0);
        wait_drain(50);
        issue(400, 0, 1, 1, 2, M_ERR, 0, 0, 0);
        wait_drain(50);
`endif
        // Exact bottom-right pixel is in range in both builds: 383999.
        issue(399, 479, 1, 1, 4, M_FILL, 192000, 1, 1);
        wait_drain(50);

        // Zero width: accepted, done next cycle, no writes.
        issue(10, 10, 0, 5, 1, M_DONE, 0, 0, 0);
        wait_drain(50);

        // Reset mid-fill with front_buf=1.
        do_swap(2);
        issue(0, 0, 50, 2, 6, M_FILL, 0, 50, 2);
        repeat (10) @(negedge clock);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_fb_we", 32'(bus_if.fb_we), 32'd0);
        chk("midrst_busy", 32'(bus_if.busy), 32'd0);
        chk("midrst_front_buf", 32'(bus_if.front_buf), 32'd0);
        chk("midrst_ready", 32'(bus_if.cmd_ready), 32'd0);
        exp_front = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("after_rst_ready", 32'(bus_if.cmd_ready), 32'd1);
        chk("after_rst_state", 32'(bus_if.dbg_state), 32'd0);

        // Engine usable after reset, back buffer 1 again: 192401.
        issue(1, 1, 1, 1, 12, M_FILL, 192000, 1, 1);
        wait_drain(50);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
